// File: rtl/wb_dsp_copy_engine_if.sv
// Command/status and master-request bundle for wb_dsp_copy_engine.
// The checksum signal exists only when COPY_CHECKSUM_EN is defined.
interface wb_dsp_copy_engine_if #(
  parameter int aw = 32,
  parameter int dw = 32,
  parameter int LW = 16
);
  logic          go;
  logic          abort;
  logic [aw-1:0] src_addr;
  logic [aw-1:0] dst_addr;
  logic [LW-1:0] len;
  logic          busy;
  logic          done;
  logic          error;
  logic [LW-1:0] count;
  logic          m_start;
  logic [aw-1:0] m_address;
  logic [3:0]    m_selection;
  logic          m_write;
  logic [dw-1:0] m_data_wr;
  logic [dw-1:0] m_data_rd;
  logic          m_done;
  logic          m_err;
`ifdef COPY_CHECKSUM_EN
  logic [dw-1:0] checksum;

  modport master (
    input  go, abort, src_addr, dst_addr, len, m_data_rd, m_done, m_err,
    output busy, done, error, count, m_start, m_address, m_selection,
           m_write, m_data_wr, checksum
  );
  modport slave (
    output go, abort, src_addr, dst_addr, len, m_data_rd, m_done, m_err,
    input  busy, done, error, count, m_start, m_address, m_selection,
           m_write, m_data_wr, checksum
  );
`else
  modport master (
    input  go, abort, src_addr, dst_addr, len, m_data_rd, m_done, m_err,
    output busy, done, error, count, m_start, m_address, m_selection,
           m_write, m_data_wr
  );
  modport slave (
    output go, abort, src_addr, dst_addr, len, m_data_rd, m_done, m_err,
    input  busy, done, error, count, m_start, m_address, m_selection,
           m_write, m_data_wr
  );
`endif
endinterface

// File: rtl/wb_dsp_copy_engine.sv
// Word-copy sequencer: alternates single read/write requests to the Wishbone master stage.
// Optional running checksum of written words is enabled with COPY_CHECKSUM_EN.
module wb_dsp_copy_engine #(
  parameter int aw = 32,
  parameter int dw = 32,
  parameter int LW = 16
) (
  input  logic                  wb_clk,
  input  logic                  wb_rst_n,
  wb_dsp_copy_engine_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_WR_WAIT, S_FINISH, S_FAIL
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [aw-1:0] r_src;
  logic [aw-1:0] r_dst;
  logic [LW-1:0] r_len;
  logic [LW-1:0] r_count;
  logic [dw-1:0] r_buf;
  logic          r_error;
`ifdef COPY_CHECKSUM_EN
  logic [dw-1:0] r_checksum;
`endif

  logic          w_accept;
  logic          w_rd_ok;
  logic          w_wr_ok;
  logic          w_wr_phase;
  logic          w_rd_phase;
  logic [LW-1:0] w_count_inc;

  assign w_accept    = (r_state == S_IDLE) && bus.go;
  // m_err takes priority over a coincident m_done
  assign w_rd_ok     = (r_state == S_RD_WAIT) && bus.m_done && !bus.m_err;
  assign w_wr_ok     = (r_state == S_WR_WAIT) && bus.m_done && !bus.m_err;
  assign w_rd_phase  = (r_state == S_RD_REQ) || (r_state == S_RD_WAIT);
  assign w_wr_phase  = (r_state == S_WR_REQ) || (r_state == S_WR_WAIT);
  assign w_count_inc = r_count + LW'(1);

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) r_state <= S_IDLE;
    else           r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (bus.go) w_state_next = (bus.len == '0) ? S_FINISH : S_RD_REQ;
      S_RD_REQ:  w_state_next = S_RD_WAIT;
      S_RD_WAIT: begin
        if (bus.m_err)       w_state_next = S_FAIL;
        else if (bus.m_done) w_state_next = S_WR_REQ;
      end
      S_WR_REQ:  w_state_next = S_WR_WAIT;
      S_WR_WAIT: begin
        if (bus.m_err)       w_state_next = S_FAIL;
        else if (bus.m_done) w_state_next = ((w_count_inc == r_len) || bus.abort) ? S_FINISH : S_RD_REQ;
      end
      S_FINISH:  w_state_next = S_IDLE;
      S_FAIL:    w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_src      <= '0;
      r_dst      <= '0;
      r_len      <= '0;
      r_count    <= '0;
      r_buf      <= '0;
      r_error    <= 1'b0;
`ifdef COPY_CHECKSUM_EN
      r_checksum <= '0;
`endif
    end else begin
      if (w_accept) begin
        r_src      <= bus.src_addr;
        r_dst      <= bus.dst_addr;
        r_len      <= bus.len;
        r_count    <= '0;
        r_error    <= 1'b0;
`ifdef COPY_CHECKSUM_EN
        r_checksum <= '0;
`endif
      end
      if (w_rd_ok) r_buf <= bus.m_data_rd;
      // pointers wrap silently at the top of the address space
      if (w_wr_ok) begin
        r_count    <= w_count_inc;
        r_src      <= r_src + aw'(4);
        r_dst      <= r_dst + aw'(4);
`ifdef COPY_CHECKSUM_EN
        r_checksum <= r_checksum + r_buf;
`endif
      end
      if (r_state == S_FAIL) r_error <= 1'b1;
    end
  end

  always_comb begin
    bus.busy      = (r_state != S_IDLE);
    bus.done      = (r_state == S_FINISH);
    bus.m_start   = (r_state == S_RD_REQ) || (r_state == S_WR_REQ);
    bus.m_write   = w_wr_phase;
    bus.m_address = '0;
    bus.m_data_wr = '0;
    if (w_rd_phase) bus.m_address = r_src;
    if (w_wr_phase) begin
      bus.m_address = r_dst;
      bus.m_data_wr = r_buf;
    end
  end

  assign bus.error       = r_error;
  assign bus.count       = r_count;
  assign bus.m_selection = 4'hF;
`ifdef COPY_CHECKSUM_EN
  assign bus.checksum    = r_checksum;
`endif

endmodule

// File: tb/tb_wb_dsp_copy_engine.sv
// Directed and randomized checks of wb_dsp_copy_engine against a word-level copy model.
// Checksum comparisons are active when COPY_CHECKSUM_EN is defined.
module tb_wb_dsp_copy_engine;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wb_dsp_copy_engine_if #(.aw(32), .dw(32), .LW(16)) bus ();

  wb_dsp_copy_engine #(.aw(32), .dw(32), .LW(16)) dut (
    .wb_clk   (clk),
    .wb_rst_n (rst_n),
    .bus      (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model of the memory behind the master: word address -> data
  logic [31:0] mem [logic [31:0]];
  logic [31:0] model_sum;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = $urandom;
    return mem[a];
  endfunction

  task automatic drive_idle();
    bus.go = 1'b0; bus.abort = 1'b0;
    bus.src_addr = '0; bus.dst_addr = '0; bus.len = '0;
    bus.m_data_rd = '0; bus.m_done = 1'b0; bus.m_err = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, " busy"},      bus.busy, 0);
    check({tag, " done"},      bus.done, 0);
    check({tag, " error"},     bus.error, 0);
    check({tag, " m_start"},   bus.m_start, 0);
    check({tag, " m_write"},   bus.m_write, 0);
    check({tag, " count"},     bus.count, 0);
    check({tag, " m_address"}, bus.m_address, 0);
    check({tag, " m_data_wr"}, bus.m_data_wr, 0);
    check({tag, " m_sel"},     bus.m_selection, 4'hF);
  endtask

  // err_xfer: transfer index (reads even, writes odd) answered with m_err, -1 for none.
  // abort_word: word whose read request raises abort, -1 for none.
  task automatic run_copy(input string name, input logic [31:0] src, input logic [31:0] dst,
                          input int n, input int err_xfer, input int abort_word, input int max_lat);
    logic [31:0] e_addr[$];
    logic        e_wr[$];
    logic [31:0] e_data[$];
    logic [31:0] ra, wa, d;
    int words, issued, cnt_exp, done_exp, err_exp, dones, lat, k;
    words    = (abort_word >= 0 && abort_word < n) ? abort_word + 1 : n;
    issued   = 2 * words;
    err_exp  = 0;
    done_exp = 1;
    cnt_exp  = words;
    if (err_xfer >= 0 && err_xfer < issued) begin
      issued   = err_xfer + 1;
      err_exp  = 1;
      done_exp = 0;
      cnt_exp  = err_xfer / 2;
    end
    model_sum = '0;
    d = '0;
    for (int w = 0; w < words; w++) begin
      ra = src + 32'(4 * w);
      wa = dst + 32'(4 * w);
      if (2 * w < issued) begin
        d = mem_rd(ra);
        e_addr.push_back(ra); e_wr.push_back(1'b0); e_data.push_back(d);
      end
      if (2 * w + 1 < issued) begin
        e_addr.push_back(wa); e_wr.push_back(1'b1); e_data.push_back(d);
        if (2 * w + 1 != err_xfer) begin
          mem[wa] = d;
          model_sum += d;
        end
      end
    end

    @(negedge clk);
    bus.src_addr = src; bus.dst_addr = dst; bus.len = 16'(n); bus.go = 1'b1;
    @(negedge clk);
    bus.go = 1'b0; bus.src_addr = $urandom; bus.dst_addr = $urandom; bus.len = 16'($urandom);
    check({name, " busy after go"}, bus.busy, 1);
    dones = 0;
    for (int t = 0; t < issued; t++) begin
      k = 0;
      while (!bus.m_start && k < 50) begin
        if (bus.done) dones++;
        @(negedge clk);
        k++;
      end
      if (!bus.m_start) begin
        check($sformatf("%s t%0d request timeout", name, t), 0, 1);
        break;
      end
      check($sformatf("%s t%0d addr", name, t), bus.m_address, e_addr[t]);
      check($sformatf("%s t%0d write", name, t), bus.m_write, e_wr[t]);
      if (e_wr[t]) check($sformatf("%s t%0d wdata", name, t), bus.m_data_wr, e_data[t]);
      check($sformatf("%s t%0d count", name, t), bus.count, t / 2);
      check($sformatf("%s t%0d sel", name, t), bus.m_selection, 4'hF);
      if (t == 2 * abort_word) bus.abort = 1'b1;
      @(negedge clk);
      if (t == 1) begin
        bus.go = 1'b1; bus.len = '0;
      end
      lat = $urandom_range(0, max_lat);
      for (int c = 0; c <= lat; c++) begin
        if (c > 0) @(negedge clk);
        check($sformatf("%s t%0d hold", name, t),
              {bus.m_start, bus.m_write, bus.m_address},
              {1'b0, e_wr[t], e_addr[t]});
      end
      if (t == err_xfer) begin
        bus.m_err  = 1'b1;
        bus.m_done = 1'($urandom_range(0, 1));
      end else begin
        bus.m_done = 1'b1;
      end
      if (!e_wr[t]) bus.m_data_rd = e_data[t];
      @(negedge clk);
      bus.m_done = 1'b0; bus.m_err = 1'b0; bus.go = 1'b0; bus.m_data_rd = $urandom;
    end
    check({name, " done after last xfer"}, bus.done, done_exp);
    k = 0;
    while (bus.busy && k < 20) begin
      if (bus.done) dones++;
      @(negedge clk);
      k++;
    end
    check({name, " busy low"}, bus.busy, 0);
    check({name, " done pulses"}, dones, done_exp);
    check({name, " count final"}, bus.count, cnt_exp);
    check({name, " error"}, bus.error, err_exp);
`ifdef COPY_CHECKSUM_EN
    check({name, " checksum"}, bus.checksum, model_sum);
`endif
    bus.abort = 1'b0;
    $display("copy %s src=%08h dst=%08h len=%0d err_xfer=%0d abort_word=%0d count=%0d error=%0d",
             name, src, dst, n, err_xfer, abort_word, bus.count, bus.error);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, ex, ab;
    drive_idle();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);

    mem[32'h1000] = 32'hA; mem[32'h1004] = 32'hB; mem[32'h1008] = 32'hC;
    run_copy("copy3", 32'h1000, 32'h2000, 3, -1, -1, 0);
`ifdef COPY_CHECKSUM_EN
    check("copy3 checksum const", bus.checksum, 32'h21);
`endif

    run_copy("err2nd", 32'h5000, 32'h6000, 4, 2, -1, 1);
    repeat (3) @(negedge clk);
    check("error sticky", bus.error, 1);

    bus.len = '0; bus.go = 1'b1;
    @(negedge clk);
    bus.go = 1'b0;
    check("len0 done", bus.done, 1);
    check("len0 busy", bus.busy, 1);
    check("len0 no start", bus.m_start, 0);
    check("len0 error cleared", bus.error, 0);
    @(negedge clk);
    check("len0 busy low", bus.busy, 0);
    check("len0 done low", bus.done, 0);
    check("len0 no start 2", bus.m_start, 0);
    $display("copy len0 done=1 after one cycle");

    run_copy("abort", 32'h7000, 32'h8000, 5, -1, 0, 2);
    run_copy("wrap", 32'hFFFF_FFFC, 32'h9000, 2, -1, -1, 1);

    for (int r = 0; r < 10; r++) begin
      n  = $urandom_range(1, 6);
      ex = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2 * n - 1)) : -1;
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      run_copy($sformatf("rnd%0d", r), $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
               n, ex, ab, 3);
    end

    // Reset asserted while the first write is outstanding
    @(negedge clk);
    bus.src_addr = 32'h3000; bus.dst_addr = 32'h4000; bus.len = 16'd3; bus.go = 1'b1;
    @(negedge clk);
    bus.go = 1'b0;
    @(negedge clk);
    bus.m_done = 1'b1; bus.m_data_rd = 32'h1234_5678;
    @(negedge clk);
    bus.m_done = 1'b0;
    @(negedge clk);
    check("pre-reset in write wait", {bus.m_write, bus.m_address}, {1'b1, 32'h4000});
    #2 rst_n = 1'b0;
    #1 check_reset("async reset");
    @(negedge clk);
    rst_n = 1'b1;
    $display("copy reset-mid-copy outputs cleared");
    run_copy("post_rst", 32'h3000, 32'h4000, 2, -1, -1, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
